// File: rtl/i2c_pad_sequencer_pkg.sv
// i2c_pad_sequencer_pkg: shared FSM states, quarter indices and byte length
package i2c_pad_sequencer_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_HOLD} state_t;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    localparam int BITS_PER_BYTE = 9;
    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: CLK_DIV down-counter emitting one tick per quarter SCL period
// clk, rst_n : system clock, async active-low reset
// reload     : restart a full quarter (command accepted)
// freeze     : hold the count (clock stretching)
// tick       : high in the last cycle of a quarter
module i2c_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic freeze,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == '0 && !freeze;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= TOP;
        else cnt <= (reload || tick) ? TOP : freeze ? cnt : cnt - W'(1);
    end
endmodule

// File: rtl/i2c_pad_sequencer.sv
// i2c_pad_sequencer: byte-level open-drain I2C master sequencing the SDA/SCL pad enables
// clk, rst_n       : system clock, async active-low reset
// cmd_*            : one-byte command (start/stop/read flags, ACK to send, write data), valid/ready
// rsp_*            : completion pulse with received byte and sampled write ACK
// busy             : bus owned from START until STOP completes
// sda_*/scl_*      : pad enable (1 = pull low), pad data (always 0), synchronised pad input
module i2c_pad_sequencer
    import i2c_pad_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack_out,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       sda_en,
    output logic       scl_en,
    output logic       sda_out,
    output logic       scl_out,
    input  logic       sda_in,
    input  logic       scl_in
);
    state_t     state, state_n;
    logic [1:0] q, q_n;
    logic [3:0] bc, bc_n;
    logic [7:0] sh;
    logic       smp, rd, stp, nko, rep, tick, freeze, accept, active, done, lvl;
    assign sda_out = 1'b0;
    assign scl_out = 1'b0;
    assign active  = state == ST_START || state == ST_BIT || state == ST_STOP;
    assign accept  = cmd_valid && cmd_ready;
    // SCL is released in q1 of every active phase; a slave holding it low stretches the quarter
    assign freeze  = active && q == Q1 && !scl_in;
    assign done    = tick && q == Q3 && (state == ST_STOP || (state == ST_BIT && bc == LAST_BIT && !stp));

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .reload(accept),
        .freeze(freeze),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q     <= Q0;
            bc    <= '0;
        end else begin
            state <= state_n;
            q     <= q_n;
            bc    <= bc_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        bc_n    = bc;
        if (accept) begin
            state_n = (state == ST_IDLE || cmd_start) ? ST_START : ST_BIT;
            q_n     = Q0;
            bc_n    = '0;
        end else if (active && tick) begin
            q_n = q + 2'd1;
            if (q == Q3) begin
                bc_n    = state == ST_BIT ? bc + 4'd1 : '0;
                state_n = state == ST_START ? ST_BIT : state == ST_STOP ? ST_IDLE :
                          bc != LAST_BIT ? ST_BIT : stp ? ST_STOP : ST_HOLD;
            end
        end
    end

    always_comb begin
        // SDA level for the current bit: ACK slot is released on writes, master ACK/NACK on reads
        lvl       = bc == LAST_BIT ? (!rd || nko) : (rd || sh[7]);
        cmd_ready = state == ST_IDLE || state == ST_HOLD;
        busy      = state != ST_IDLE;
        sda_en    = state == ST_START ? q[1] : state == ST_BIT ? !lvl : state == ST_STOP ? !q[1] : 1'b0;
        // a repeated START keeps SCL low through q0 so no stray clock pulse appears
        scl_en    = state == ST_START ? (q == Q3 || (q == Q0 && rep)) :
                    state == ST_BIT  ? (q == Q0 || q == Q3) :
                    state == ST_STOP ? q == Q0 : state == ST_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh        <= '0;
            smp       <= 1'b0;
            rd        <= 1'b0;
            stp       <= 1'b0;
            nko       <= 1'b0;
            rep       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (accept) begin
                sh  <= cmd_wdata;
                rd  <= cmd_read;
                stp <= cmd_stop;
                nko <= cmd_nack_out;
                rep <= state == ST_HOLD;
            end
            if (tick && state == ST_BIT && q == Q2) smp <= sda_in;
            // shift only at the end of the bit so SDA never moves while SCL is high
            if (tick && state == ST_BIT && q == Q3 && bc != LAST_BIT) sh <= {sh[6:0], smp};
            if (done) begin
                rsp_rdata <= rd ? sh : 8'h00;
                rsp_nack  <= !rd && smp;
            end
        end
    end
endmodule

// File: tb/tb_i2c_pad_sequencer.sv
// tb_i2c_pad_sequencer: directed bench with an open-drain bus and a simple slave model
module tb_i2c_pad_sequencer;
    localparam int D = 4;
    logic       clk = 0, rst_n = 1;
    logic       cmd_valid = 0, cmd_start = 0, cmd_stop = 0, cmd_read = 0, cmd_nack_out = 0;
    logic [7:0] cmd_wdata = 0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, sda_en, scl_en, sda_out, scl_out;
    logic [7:0] rsp_rdata;
    logic       sda_in, scl_in, scl_m;
    logic       slave_low = 0, stretch = 0, arm = 0;
    logic [7:0] rbyte = 0;
    logic       prev_scl = 1, prev_sda = 1;
    logic       rises[$];
    int mode = 0, errs = 0, checks = 0, cyc = 0, acc = 0, base_lat = 0;
    int falls = 0, starts = 0, stops = 0, rvs = 0, st_cnt = 0, od_bad = 0;

    assign scl_m  = ~scl_en;
    assign scl_in = scl_m & ~stretch;
    assign sda_in = ~sda_en & ~slave_low;

    i2c_pad_sequencer #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_read(cmd_read), .cmd_nack_out(cmd_nack_out), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .sda_en(sda_en), .scl_en(scl_en), .sda_out(sda_out), .scl_out(scl_out),
        .sda_in(sda_in), .scl_in(scl_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor and slave: edges seen on the master-driven SCL, slave acts after SCL falls
    always @(negedge clk) begin
        if (rsp_valid) rvs++;
        if (sda_out || scl_out) od_bad++;
        if (stretch) begin
            st_cnt++;
            if (st_cnt == 100) stretch = 0;
        end
        if (!prev_scl && scl_m) begin
            rises.push_back(sda_in);
            if (arm && rises.size() == 4) begin
                arm = 0;
                stretch = 1;
                st_cnt = 0;
            end
        end
        if (prev_scl && scl_m && prev_sda && !sda_in) begin
            starts++;
            falls = 0;
            rises.delete();
            slave_low = 0;
        end
        if (prev_scl && scl_m && !prev_sda && sda_in) stops++;
        if (prev_scl && !scl_m) begin
            falls++;
            slave_low = mode == 1 && falls == 9;
            if (mode == 2 && falls <= 8) slave_low = !rbyte[8 - falls];
        end
        prev_scl = scl_m;
        prev_sda = sda_in;
    end

    function automatic logic [8:0] pat();
        logic [8:0] p = 'x;
        for (int i = 0; i < 9; i++) if (i < rises.size()) p[8 - i] = rises[i];
        return p;
    endfunction

    task automatic send(input logic st, input logic sp, input logic rdc, input logic nk, input logic [7:0] wd);
        int n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1; cmd_start = st; cmd_stop = sp; cmd_read = rdc; cmd_nack_out = nk; cmd_wdata = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - acc;
        checks++;
        if (rsp_valid !== 1'b1) begin errs++; $display("FAIL rsp_timeout got=%b exp=1 after %0d cycles", rsp_valid, n); end
    endtask

    task automatic test_reset();
        #3 rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sda_en, scl_en, sda_out, scl_out, cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata} !== 16'h0800) begin
            errs++;
            $display("FAIL reset_state got=%h exp=0800", {sda_en, scl_en, sda_out, scl_out, cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata});
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat, s0, p0;
        mode = 1; s0 = starts; p0 = stops;
        send(1, 1, 0, 0, 8'hA5);
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin errs++; $display("FAIL wr_inflight got=%b exp=01", {cmd_ready, busy}); end
        wait_rsp(lat);
        base_lat = lat;
        checks++;
        if (lat < 175 || lat > 177) begin errs++; $display("FAIL wr_latency got=%0d exp=176", lat); end
        checks++;
        if ({rsp_nack, rsp_rdata} !== 9'h000) begin errs++; $display("FAIL wr_rsp got=%h exp=000", {rsp_nack, rsp_rdata}); end
        checks++;
        if (pat() !== {8'hA5, 1'b0}) begin errs++; $display("FAIL wr_sda_bits got=%b exp=%b", pat(), {8'hA5, 1'b0}); end
        checks++;
        if (starts !== s0 + 1 || stops !== p0 + 1) begin errs++; $display("FAIL wr_start_stop got=%0d/%0d exp=%0d/%0d", starts, stops, s0 + 1, p0 + 1); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin errs++; $display("FAIL wr_after got=%b exp=010", {rsp_valid, cmd_ready, busy}); end
    endtask

    task automatic test_read();
        int lat, p0;
        mode = 2; rbyte = 8'h3C; p0 = stops;
        send(1, 1, 1, 1, 8'hFF);
        wait_rsp(lat);
        checks++;
        if ({rsp_nack, rsp_rdata} !== {1'b0, 8'h3C}) begin errs++; $display("FAIL rd_rsp got=%h exp=03c", {rsp_nack, rsp_rdata}); end
        checks++;
        if (pat() !== {8'h3C, 1'b1}) begin errs++; $display("FAIL rd_sda_bits got=%b exp=%b", pat(), {8'h3C, 1'b1}); end
        checks++;
        if (stops !== p0 + 1) begin errs++; $display("FAIL rd_stop got=%0d exp=%0d", stops, p0 + 1); end
        checks++;
        if (lat < 175 || lat > 177) begin errs++; $display("FAIL rd_latency got=%0d exp=176", lat); end
    endtask

    task automatic test_nack();
        int lat, p0;
        mode = 0; p0 = stops;
        send(1, 1, 0, 0, 8'h55);
        wait_rsp(lat);
        checks++;
        if ({rsp_nack, rsp_rdata} !== 9'h100) begin errs++; $display("FAIL nack_rsp got=%h exp=100", {rsp_nack, rsp_rdata}); end
        checks++;
        if (pat() !== {8'h55, 1'b1}) begin errs++; $display("FAIL nack_sda_bits got=%b exp=%b", pat(), {8'h55, 1'b1}); end
        checks++;
        if (stops !== p0 + 1) begin errs++; $display("FAIL nack_stop got=%0d exp=%0d", stops, p0 + 1); end
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin errs++; $display("FAIL nack_idle got=%b exp=10", {cmd_ready, busy}); end
    endtask

    task automatic test_stretch();
        int lat;
        mode = 1; arm = 1;
        send(1, 1, 0, 0, 8'hA5);
        wait_rsp(lat);
        checks++;
        if (lat - base_lat !== 100) begin errs++; $display("FAIL stretch_delay got=%0d exp=100", lat - base_lat); end
        checks++;
        if ({rsp_nack, pat()} !== {1'b0, 8'hA5, 1'b0}) begin errs++; $display("FAIL stretch_data got=%b exp=0%b", {rsp_nack, pat()}, {8'hA5, 1'b0}); end
    endtask

    task automatic test_hold_rep();
        int lat, s0, p0;
        mode = 1; p0 = stops;
        send(1, 0, 0, 0, 8'h40);
        wait_rsp(lat);
        checks++;
        if (lat < 159 || lat > 161) begin errs++; $display("FAIL hold_latency got=%0d exp=160", lat); end
        checks++;
        if ({rsp_nack, pat()} !== {1'b0, 8'h40, 1'b0}) begin errs++; $display("FAIL hold_data got=%b exp=0%b", {rsp_nack, pat()}, {8'h40, 1'b0}); end
        repeat (20) @(negedge clk);
        checks++;
        if ({busy, cmd_ready, scl_en, sda_en} !== 4'b1110) begin errs++; $display("FAIL hold_lines got=%b exp=1110", {busy, cmd_ready, scl_en, sda_en}); end
        checks++;
        if (stops !== p0) begin errs++; $display("FAIL hold_nostop got=%0d exp=%0d", stops, p0); end
        s0 = starts;
        mode = 2; rbyte = 8'h96;
        send(1, 1, 1, 1, 8'h00);
        wait_rsp(lat);
        checks++;
        if (starts !== s0 + 1) begin errs++; $display("FAIL rep_start got=%0d exp=%0d", starts, s0 + 1); end
        checks++;
        if ({rsp_nack, rsp_rdata} !== {1'b0, 8'h96}) begin errs++; $display("FAIL rep_rsp got=%h exp=096", {rsp_nack, rsp_rdata}); end
        checks++;
        if (lat < 175 || lat > 177 || stops !== p0 + 1) begin errs++; $display("FAIL rep_latency_stop got=%0d/%0d exp=176/%0d", lat, stops, p0 + 1); end
    endtask

    task automatic test_reset_mid();
        int lat, s0, p0, r0, n = 0;
        mode = 1; p0 = stops;
        send(1, 1, 0, 0, 8'h00);
        while (!(rises.size() >= 6 && scl_en) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin errs++; $display("FAIL mid_reach_bit5 got=timeout exp=bit5"); end
        r0 = rvs;
        rst_n = 0;
        #1;
        checks++;
        if ({sda_en, scl_en, busy} !== 3'b000) begin errs++; $display("FAIL mid_release got=%b exp=000", {sda_en, scl_en, busy}); end
        repeat (50) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        checks++;
        if (rvs !== r0 || stops !== p0) begin errs++; $display("FAIL mid_no_rsp_stop got=%0d/%0d exp=%0d/%0d", rvs, stops, r0, p0); end
        s0 = starts;
        send(0, 1, 0, 0, 8'h81);
        wait_rsp(lat);
        checks++;
        if (starts !== s0 + 1) begin errs++; $display("FAIL mid_fresh_start got=%0d exp=%0d", starts, s0 + 1); end
        checks++;
        if ({rsp_nack, pat()} !== {1'b0, 8'h81, 1'b0}) begin errs++; $display("FAIL mid_next_data got=%b exp=0%b", {rsp_nack, pat()}, {8'h81, 1'b0}); end
        checks++;
        if (lat < 175 || lat > 177) begin errs++; $display("FAIL mid_latency got=%0d exp=176", lat); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_stretch();
        test_hold_rep();
        test_reset_mid();
        checks++;
        if (od_bad !== 0) begin errs++; $display("FAIL pad_out_driven got=%0d exp=0", od_bad); end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
